// File: rtl/weight_stream_memory.sv
// weight_stream_memory
//   Multi-lane weight store for a layer of parallel neurons. numLanes banks of
//   numWeight x dataWidth words are loaded over a config write port. A stream
//   sequencer walks every bank in lockstep from address 0 to numWeight-1 and
//   presents one word per lane on each issued beat.
//
//   Handshake: rd_en is the consumer's request to advance. Each STREAM cycle
//   with rd_en=1 issues exactly one beat, and that beat appears on wout with
//   wvalid=1 on the following cycle. There is no backpressure on wvalid: a
//   beat is presented once and is never held or repeated. The consumer throttles
//   the stream only by deasserting rd_en.
module weight_stream_memory #(
  parameter int numWeight    = 784,
  parameter int numLanes     = 4,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int laneWidth    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [laneWidth-1:0]          wlane,
  input  logic [addressWidth-1:0]       wadd,
  input  logic [dataWidth-1:0]          win,
  output logic                          werr,
  input  logic                          start,
  input  logic                          rd_en,
  output logic [numLanes*dataWidth-1:0] wout,
  output logic                          wvalid,
  output logic                          wlast,
  output logic                          busy
);

  // Index widths that exactly match the bank array dimensions.
  localparam int LIW = (numLanes > 1) ? $clog2(numLanes) : 1;
  localparam int AIW = $clog2(numWeight);

  // Range limits, one bit wider than the ports so the limit itself fits.
  localparam logic [laneWidth:0]      LANE_LIMIT = (laneWidth + 1)'(numLanes);
  localparam logic [addressWidth:0]   WORD_LIMIT = (addressWidth + 1)'(numWeight);
  localparam logic [addressWidth-1:0] LAST_ADDR  = addressWidth'(numWeight - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [addressWidth-1:0]       rd_ptr_q, rd_ptr_d;
  logic [numLanes*dataWidth-1:0] wout_q, wout_d;
  logic                          wvalid_q, wvalid_d;
  logic                          wlast_q, wlast_d;
  logic                          werr_q, werr_d;

  logic [dataWidth-1:0]          mem [numLanes][numWeight];
  logic [numLanes*dataWidth-1:0] rd_bus;
  logic                          wr_ok;
  logic [LIW-1:0]                wlane_idx;
  logic [AIW-1:0]                wadd_idx;
  logic [AIW-1:0]                rd_idx;

  // A write lands only when both the lane and the word are inside the store.
  assign wr_ok     = ({1'b0, wlane} < LANE_LIMIT) && ({1'b0, wadd} < WORD_LIMIT);
  assign wlane_idx = wlane[LIW-1:0];
  assign wadd_idx  = wadd[AIW-1:0];
  assign rd_idx    = rd_ptr_q[AIW-1:0];

  // Bank storage: no reset, contents survive rst. The stream read below samples
  // the pre-edge word, so a same-cycle write to the read address is read-first.
  always_ff @(posedge clk) begin
    if (wen && wr_ok) begin
      mem[wlane_idx][wadd_idx] <= win;
    end
  end

  // Every lane is read at the shared stream pointer.
  for (genvar k = 0; k < numLanes; k++) begin : g_lane_rd
    assign rd_bus[k*dataWidth +: dataWidth] = mem[k][rd_idx];
  end

  // Next-state, pointer and output-register logic for the stream sequencer.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wout_d   = wout_q;
    wvalid_d = 1'b0;
    wlast_d  = 1'b0;
    werr_d   = wen && !wr_ok;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_STREAM;
          rd_ptr_d = '0;
        end
      end
      S_STREAM: begin
        if (rd_en) begin
          wvalid_d = 1'b1;
          wout_d   = rd_bus;
          if (rd_ptr_q == LAST_ADDR) begin
            wlast_d  = 1'b1;
            rd_ptr_d = '0;
            state_d  = S_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        rd_ptr_d = '0;
      end
    endcase
  end

  // State and output registers; rst aborts any stream immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wout_q   <= '0;
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wout_q   <= wout_d;
      wvalid_q <= wvalid_d;
      wlast_q  <= wlast_d;
      werr_q   <= werr_d;
    end
  end

  // busy is the FSM state itself, so it also serves as the state observation point.
  assign busy   = (state_q == S_STREAM);
  assign wout   = wout_q;
  assign wvalid = wvalid_q;
  assign wlast  = wlast_q;
  assign werr   = werr_q;

endmodule

// File: tb/tb_weight_stream_memory.sv
// Bench for weight_stream_memory: small configuration (8 words x 4 lanes),
// directed table vectors, hand-written corner sequences and random traffic
// checked against a beat-level reference model.
module tb_weight_stream_memory;

  localparam int NW = 8;
  localparam int NL = 4;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int LW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wen;
  logic [LW-1:0]     wlane;
  logic [AW-1:0]     wadd;
  logic [DW-1:0]     win;
  logic              werr;
  logic              start;
  logic              rd_en;
  logic [NL*DW-1:0]  wout;
  logic              wvalid;
  logic              wlast;
  logic              busy;

  weight_stream_memory #(
    .numWeight(NW), .numLanes(NL), .addressWidth(AW),
    .dataWidth(DW), .laneWidth(LW)
  ) dut (
    .clk(clk), .rst(rst), .wen(wen), .wlane(wlane), .wadd(wadd), .win(win),
    .werr(werr), .start(start), .rd_en(rd_en), .wout(wout), .wvalid(wvalid),
    .wlast(wlast), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: stored words plus "streaming / next beat" bookkeeping.
  logic [DW-1:0]    ref_mem [NL][NW];
  bit               m_stream;
  int               m_beat;
  logic [NL*DW-1:0] e_wout;
  logic             e_valid, e_last, e_werr;
  int               beats_seen, lasts_seen, werr_seen;

  typedef struct {
    bit start;
    bit rd_en;
    bit e_valid;
    bit e_last;
    bit e_busy;
    int beat;   // expected beat address on wout, -1 when no beat
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NL*DW-1:0] pattern(input int a);
    logic [NL*DW-1:0] w;
    for (int k = 0; k < NL; k++) w[k*DW +: DW] = {4'(k), 12'(a)};
    return w;
  endfunction

  task automatic m_reset();
    m_stream = 1'b0;
    m_beat   = 0;
    e_wout   = '0;
    e_valid  = 1'b0;
    e_last   = 1'b0;
    e_werr   = 1'b0;
  endtask

  // One clock: advance the model on the edge with the applied inputs, then compare.
  task automatic cycle();
    bit ok;
    @(posedge clk);
    ok = (int'(wlane) < NL) && (int'(wadd) < NW);
    e_werr = wen && !ok;
    if (m_stream && rd_en) begin
      e_valid = 1'b1;
      for (int k = 0; k < NL; k++) e_wout[k*DW +: DW] = ref_mem[k][m_beat];
      e_last = (m_beat == NW - 1);
      m_beat++;
      if (m_beat == NW) begin
        m_beat   = 0;
        m_stream = 1'b0;
      end
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
      if (!m_stream && start) begin
        m_stream = 1'b1;
        m_beat   = 0;
      end
    end
    if (wen && ok) ref_mem[int'(wlane)][int'(wadd)] = win;
    #1;
    check("wvalid", 64'(wvalid), 64'(e_valid));
    check("wlast",  64'(wlast),  64'(e_last));
    check("werr",   64'(werr),   64'(e_werr));
    check("busy",   64'(busy),   64'(m_stream));
    check("wout",   64'(wout),   64'(e_wout));
    if (wvalid === 1'b1) beats_seen++;
    if (wlast === 1'b1) lasts_seen++;
    if (werr === 1'b1) werr_seen++;
  endtask

  task automatic idle_inputs();
    wen = 1'b0; wlane = '0; wadd = '0; win = '0; start = 1'b0; rd_en = 1'b0;
  endtask

  task automatic load_pattern();
    for (int k = 0; k < NL; k++) begin
      for (int a = 0; a < NW; a++) begin
        wen = 1'b1; wlane = LW'(k); wadd = AW'(a); win = {4'(k), 12'(a)};
        cycle();
      end
    end
    wen = 1'b0;
  endtask

  task automatic full_stream();
    start = 1'b1; cycle(); start = 1'b0;
    rd_en = 1'b1;
    repeat (NW) cycle();
    rd_en = 1'b0;
    cycle();
  endtask

  task automatic add(input bit s, input bit r, input bit v, input bit l, input bit b, input int beat);
    vec_t e;
    e.start = s; e.rd_en = r; e.e_valid = v; e.e_last = l; e.e_busy = b; e.beat = beat;
    vq.push_back(e);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    idle_inputs();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_wlast",  64'(wlast),  64'd0);
    check("rst_werr",   64'(werr),   64'd0);
    check("rst_wout",   64'(wout),   64'd0);
    rst = 1'b0;
    cycle();

    // 1: load pattern, stream with rd_en held high
    load_pattern();
    beats_seen = 0; lasts_seen = 0;
    start = 1'b1; cycle(); start = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < NW; i++) begin
      cycle();
      check("t1_beat_data", 64'(wout), 64'(pattern(i)));
      check("t1_busy", 64'(busy), 64'(i != NW - 1));
    end
    rd_en = 1'b0;
    cycle();
    check("t1_beats", 64'(beats_seen), 64'(NW));
    check("t1_lasts", 64'(lasts_seen), 64'd1);

    // 2 and 6: gapped rd_en, ignored starts, earliest restart
    add(1, 1, 0, 0, 1, -1);  // rd_en ignored in IDLE
    add(0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1, -1);
    add(0, 0, 0, 0, 1, -1);
    add(0, 1, 1, 0, 1, 1);
    add(1, 1, 1, 0, 1, 2);   // start ignored in STREAM
    add(0, 0, 0, 0, 1, -1);
    add(0, 1, 1, 0, 1, 3);
    add(0, 1, 1, 0, 1, 4);
    add(1, 1, 1, 0, 1, 5);
    add(0, 0, 0, 0, 1, -1);
    add(0, 1, 1, 0, 1, 6);
    add(1, 1, 1, 1, 0, 7);   // start in the final STREAM cycle ignored
    add(1, 1, 0, 0, 1, -1);  // earliest restart; rd_en ignored in IDLE
    for (int i = 0; i < NW; i++) add(i % 3 == 0, 1, 1, i == NW - 1, i != NW - 1, i);
    add(0, 1, 0, 0, 0, -1);
    beats_seen = 0;
    foreach (vq[i]) begin
      start = vq[i].start; rd_en = vq[i].rd_en;
      cycle();
      check("tab_wvalid", 64'(wvalid), 64'(vq[i].e_valid));
      check("tab_wlast",  64'(wlast),  64'(vq[i].e_last));
      check("tab_busy",   64'(busy),   64'(vq[i].e_busy));
      if (vq[i].beat >= 0) check("tab_wout", 64'(wout), 64'(pattern(vq[i].beat)));
    end
    check("tab_beats", 64'(beats_seen), 64'(2 * NW));
    idle_inputs();
    cycle();

    // 3: out-of-range writes are rejected
    werr_seen = 0;
    wen = 1'b1; wlane = 3'd4; wadd = 4'd0; win = 16'hDEAD; cycle();
    wen = 1'b0; cycle();
    wen = 1'b1; wlane = 3'd1; wadd = 4'd8; win = 16'hDEAD; cycle();
    wen = 1'b0; cycle();
    check("t3_werr_pulses", 64'(werr_seen), 64'd2);
    beats_seen = 0;
    full_stream();
    check("t3_readback_beats", 64'(beats_seen), 64'(NW));

    // 4: read-first collision on lane 2 addr 3
    start = 1'b1; cycle(); start = 1'b0;
    rd_en = 1'b1;
    repeat (3) cycle();
    wen = 1'b1; wlane = 3'd2; wadd = 4'd3; win = 16'hBEEF;
    cycle();
    wen = 1'b0;
    check("t4_old_word", 64'(wout[2*DW +: DW]), 64'h2003);
    repeat (NW - 4) cycle();
    rd_en = 1'b0; cycle();
    start = 1'b1; cycle(); start = 1'b0;
    rd_en = 1'b1;
    repeat (4) cycle();
    check("t4_new_word", 64'(wout[2*DW +: DW]), 64'hBEEF);
    repeat (NW - 4) cycle();
    rd_en = 1'b0; cycle();

    // 5: reset mid-stream after beat 4
    start = 1'b1; cycle(); start = 1'b0;
    rd_en = 1'b1;
    repeat (5) cycle();
    #2 rst = 1'b1;
    #1;
    check("t5_busy",   64'(busy),   64'd0);
    check("t5_wvalid", 64'(wvalid), 64'd0);
    check("t5_wlast",  64'(wlast),  64'd0);
    check("t5_wout",   64'(wout),   64'd0);
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) cycle();
    rd_en = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    rd_en = 1'b1;
    cycle();
    check("t5_restart_addr0", 64'(wout), 64'(pattern(0)));
    repeat (NW - 1) cycle();
    rd_en = 1'b0; cycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      wen   = ($urandom_range(0, 3) == 0);
      wlane = LW'($urandom_range(0, 4));
      wadd  = AW'($urandom_range(0, 8));
      win   = DW'($urandom);
      start = ($urandom_range(0, 5) == 0);
      rd_en = 1'($urandom_range(0, 1));
      cycle();
    end
    idle_inputs();
    rd_en = 1'b1;
    repeat (NW + 2) cycle();
    rd_en = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
